// File: rtl/reg_bank_read_pkg.sv
// reg_bank_read_pkg: register-index constants and writereg mux encodings
package reg_bank_read_pkg;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [4:0]  REG_SP   = 5'd29;
    localparam logic [4:0]  REG_RA   = 5'd31;
    localparam logic [31:0] SP_RESET = 32'd227;

    typedef enum logic [1:0] {WR_RT, WR_RD, WR_SP, WR_RA} wr_sel_e;

    // Writereg mux: picks the destination index that the bank will write
    function automatic logic [4:0] wr_index(input wr_sel_e sel, input logic [4:0] rt, input logic [4:0] rd);
        return sel == WR_RT ? rt : sel == WR_RD ? rd : sel == WR_SP ? REG_SP : REG_RA;
    endfunction
endpackage

// File: rtl/reg_bank_read_if.sv
// reg_bank_read_if: write port, two read ports and operand-latch controls
interface reg_bank_read_if #(parameter int DATA_W = 32);
    logic              reg_write;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;
    logic [4:0]        read_reg1;
    logic [4:0]        read_reg2;
    logic              A_load;
    logic              B_load;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] A_out;
    logic [DATA_W-1:0] B_out;

    modport master (output reg_write, write_reg, write_data, read_reg1, read_reg2, A_load, B_load,
                    input read_data1, read_data2, A_out, B_out);
    modport slave  (input reg_write, write_reg, write_data, read_reg1, read_reg2, A_load, B_load,
                    output read_data1, read_data2, A_out, B_out);
endinterface

// File: rtl/reg_bank_read_operand_latch.sv
// operand_latch: async-reset load-enable operand register
module operand_latch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] q_q;

    // Capture d on a load edge, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else if (load) q_q <= d;
    end

    assign q = q_q;
endmodule

// File: rtl/reg_bank_read.sv
// reg_bank_read: 32-entry register bank with two async reads and A/B operand latches
module reg_bank_read #(
    parameter int                         DATA_W   = 32,
    parameter int                         SP_IDX   = 29,
    parameter logic [DATA_W-1:0]          SP_RESET = DATA_W'(reg_bank_read_pkg::SP_RESET)
) (
    input logic            clk,
    input logic            reset,
    reg_bank_read_if.slave bus
);
    import reg_bank_read_pkg::*;

    logic [DATA_W-1:0] regs_q [32];

    // Single write port; writes to $0 are dropped so it always reads as zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
        end else if (bus.reg_write && bus.write_reg != REG_ZERO) begin
            regs_q[bus.write_reg] <= bus.write_data;
        end
    end

    // No write bypass: reads see the pre-edge contents
    assign bus.read_data1 = (bus.read_reg1 == REG_ZERO) ? '0 : regs_q[bus.read_reg1];
    assign bus.read_data2 = (bus.read_reg2 == REG_ZERO) ? '0 : regs_q[bus.read_reg2];

    operand_latch #(.DATA_W(DATA_W)) u_a (
        .clk(clk), .reset(reset), .load(bus.A_load), .d(bus.read_data1), .q(bus.A_out)
    );

    operand_latch #(.DATA_W(DATA_W)) u_b (
        .clk(clk), .reset(reset), .load(bus.B_load), .d(bus.read_data2), .q(bus.B_out)
    );
endmodule

// File: tb/tb_reg_bank_read.sv
// tb_reg_bank_read: directed and randomized checks against an array model of the bank
module tb_reg_bank_read;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vecs = 0;
    int errs = 0;
    logic [31:0] mem [32];
    logic [31:0] a_m, b_m;

    always #5 clk = ~clk;

    reg_bank_read_if #(.DATA_W(32)) bus();
    reg_bank_read dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [31:0] mrd(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : mem[i];
    endfunction

    task automatic mreset();
        for (int i = 0; i < 32; i++) mem[i] = (i == 29) ? 32'd227 : 32'd0;
        a_m = 32'd0;
        b_m = 32'd0;
    endtask

    task automatic idle();
        bus.reg_write = 1'b0;
        bus.A_load = 1'b0;
        bus.B_load = 1'b0;
    endtask

    // Advance one rising edge and move the model the way the bank should move
    task automatic edge_step();
        logic [31:0] r1, r2;
        logic we, la, lb;
        logic [4:0] wi;
        logic [31:0] wd;
        r1 = mrd(bus.read_reg1);
        r2 = mrd(bus.read_reg2);
        we = bus.reg_write; wi = bus.write_reg; wd = bus.write_data;
        la = bus.A_load; lb = bus.B_load;
        @(posedge clk);
        #1;
        if (!reset) begin
            if (la) a_m = r1;
            if (lb) b_m = r2;
            if (we && wi != 5'd0) mem[wi] = wd;
        end
    endtask

    task automatic test_reset();
        idle();
        bus.write_reg = 5'd0; bus.write_data = 32'd0;
        bus.read_reg1 = 5'd29; bus.read_reg2 = 5'd31;
        #2 reset = 1'b1;
        mreset();
        #1;
        vecs++; if (bus.read_data1 !== 32'd227) begin errs++; $display("FAIL reset_sp got %h want %h", bus.read_data1, 32'd227); end
        vecs++; if (bus.read_data2 !== 32'd0) begin errs++; $display("FAIL reset_ra got %h want 0", bus.read_data2); end
        vecs++; if (bus.A_out !== 32'd0) begin errs++; $display("FAIL reset_a got %h want 0", bus.A_out); end
        vecs++; if (bus.B_out !== 32'd0) begin errs++; $display("FAIL reset_b got %h want 0", bus.B_out); end
        #1 reset = 1'b0;
    endtask

    task automatic test_zero_write();
        bus.reg_write = 1'b1; bus.write_reg = 5'd0; bus.write_data = 32'hDEADBEEF;
        bus.read_reg1 = 5'd0;
        edge_step();
        idle();
        vecs++; if (bus.read_data1 !== 32'd0) begin errs++; $display("FAIL zero_write got %h want 0", bus.read_data1); end
    endtask

    task automatic test_no_bypass();
        bus.reg_write = 1'b1; bus.write_reg = 5'd31; bus.write_data = 32'h00400010;
        bus.read_reg1 = 5'd31; bus.A_load = 1'b1;
        #1;
        vecs++; if (bus.read_data1 !== 32'd0) begin errs++; $display("FAIL bypass_pre got %h want 0", bus.read_data1); end
        edge_step();
        idle();
        vecs++; if (bus.read_data1 !== 32'h00400010) begin errs++; $display("FAIL bypass_post got %h want 00400010", bus.read_data1); end
        vecs++; if (bus.A_out !== 32'd0) begin errs++; $display("FAIL bypass_a got %h want 0", bus.A_out); end
    endtask

    task automatic test_latch();
        bus.reg_write = 1'b1; bus.write_reg = 5'd8; bus.write_data = 32'd5;
        edge_step();
        bus.write_reg = 5'd9; bus.write_data = 32'd7;
        edge_step();
        bus.reg_write = 1'b0; bus.read_reg1 = 5'd8; bus.read_reg2 = 5'd9;
        bus.A_load = 1'b1; bus.B_load = 1'b1;
        edge_step();
        vecs++; if (bus.A_out !== 32'd5) begin errs++; $display("FAIL latch_a got %h want 5", bus.A_out); end
        vecs++; if (bus.B_out !== 32'd7) begin errs++; $display("FAIL latch_b got %h want 7", bus.B_out); end
        idle();
        bus.reg_write = 1'b1; bus.write_reg = 5'd8; bus.write_data = 32'd99;
        edge_step();
        idle();
        vecs++; if (bus.A_out !== 32'd5) begin errs++; $display("FAIL latch_hold got %h want 5", bus.A_out); end
        vecs++; if (bus.read_data1 !== 32'd99) begin errs++; $display("FAIL latch_rd got %h want 99", bus.read_data1); end
    endtask

    task automatic test_reset_mid();
        bus.reg_write = 1'b1; bus.write_reg = 5'd29; bus.write_data = 32'd200;
        bus.read_reg1 = 5'd29; bus.read_reg2 = 5'd8;
        edge_step();
        idle();
        vecs++; if (bus.read_data1 !== 32'd200) begin errs++; $display("FAIL sp_write got %h want 200", bus.read_data1); end
        @(negedge clk);
        reset = 1'b1;
        mreset();
        #1 reset = 1'b0;
        vecs++; if (bus.read_data1 !== 32'd227) begin errs++; $display("FAIL mid_sp got %h want 227", bus.read_data1); end
        vecs++; if (bus.read_data2 !== 32'd0) begin errs++; $display("FAIL mid_r8 got %h want 0", bus.read_data2); end
        vecs++; if (bus.A_out !== 32'd0) begin errs++; $display("FAIL mid_a got %h want 0", bus.A_out); end
        reset = 1'b1;
        bus.reg_write = 1'b1; bus.write_reg = 5'd8; bus.write_data = 32'd55;
        bus.A_load = 1'b1; bus.B_load = 1'b1;
        edge_step();
        vecs++; if (bus.read_data2 !== 32'd0) begin errs++; $display("FAIL held_r8 got %h want 0", bus.read_data2); end
        vecs++; if (bus.A_out !== 32'd0) begin errs++; $display("FAIL held_a got %h want 0", bus.A_out); end
        vecs++; if (bus.read_data1 !== 32'd227) begin errs++; $display("FAIL held_sp got %h want 227", bus.read_data1); end
        @(negedge clk);
        reset = 1'b0;
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1000; n++) begin
            int sel;
            sel = $urandom_range(0, 5);
            bus.reg_write = ($urandom_range(0, 3) != 0);
            bus.write_reg = sel == 0 ? 5'd0 : sel == 1 ? 5'd29 : sel == 2 ? 5'd31 : 5'($urandom);
            bus.write_data = $urandom;
            bus.read_reg1 = ($urandom_range(0, 2) == 0) ? bus.write_reg : 5'($urandom);
            bus.read_reg2 = ($urandom_range(0, 3) == 0) ? bus.read_reg1 : 5'($urandom);
            bus.A_load = 1'($urandom);
            bus.B_load = 1'($urandom);
            #1;
            vecs++; if (bus.read_data1 !== mrd(bus.read_reg1)) begin errs++; $display("FAIL rnd_rd1 op %0d idx %0d got %h want %h", n, bus.read_reg1, bus.read_data1, mrd(bus.read_reg1)); end
            vecs++; if (bus.read_data2 !== mrd(bus.read_reg2)) begin errs++; $display("FAIL rnd_rd2 op %0d idx %0d got %h want %h", n, bus.read_reg2, bus.read_data2, mrd(bus.read_reg2)); end
            edge_step();
            vecs++; if (bus.A_out !== a_m) begin errs++; $display("FAIL rnd_a op %0d got %h want %h", n, bus.A_out, a_m); end
            vecs++; if (bus.B_out !== b_m) begin errs++; $display("FAIL rnd_b op %0d got %h want %h", n, bus.B_out, b_m); end
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            bus.read_reg1 = 5'(i);
            #1;
            vecs++; if (bus.read_data1 !== mrd(5'(i))) begin errs++; $display("FAIL final_reg %0d got %h want %h", i, bus.read_data1, mrd(5'(i))); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_write();
        test_no_bypass();
        test_latch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
